// File: rtl/gb_csr_bank.sv
// gb_csr_bank: ghostbus CSR block with NREG control registers (optional
// self-clear), one host RAM with a fabric read port, and a read-return
// pipeline of RD_LAT cycles.
// Optional build macro GB_CSR_BANK_ERR_EN adds a saturating unmapped-access
// counter at relative address NREG; without it that address reads 0.
module gb_csr_bank #(
    parameter int unsigned           AW       = 24,
    parameter int unsigned           DW       = 32,
    parameter int unsigned           GW       = 8,
    parameter int unsigned           NREG     = 4,
    parameter logic [NREG*GW-1:0]    INIT     = '0,
    parameter logic [NREG-1:0]       SC_MASK  = '0,
    parameter int unsigned           RW       = 4,
    parameter int unsigned           RD       = 8,
    parameter int unsigned           RAM_BASE = 'h40,
    parameter int unsigned           RD_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            GBPORT_addr,
    input  logic [DW-1:0]            GBPORT_dout,
    output logic [DW-1:0]            GBPORT_din,
    input  logic                     GBPORT_we,
    input  logic                     GBPORT_wstb,
    input  logic                     GBPORT_rstb,
    output logic [NREG*GW-1:0]       reg_q,
    output logic [NREG-1:0]          wr_pulse,
    input  logic [$clog2(RD)-1:0]    ram_raddr,
    output logic [RW-1:0]            ram_rdata,
    output logic                     rd_valid
);

    localparam int unsigned RAW = $clog2(RD);

    logic [NREG*GW-1:0] regs_q, regs_d;
    logic [NREG-1:0]    wr_pulse_q, wr_pulse_d;
    logic [RW-1:0]      ram_rdata_q, ram_rdata_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [DW-1:0]      dat_q [RD_LAT];
    logic [DW-1:0]      dat_d [RD_LAT];
    logic [RW-1:0]      mem [RD];

    logic               wr_en;
    logic               hit_reg;
    logic               hit_ram;
    logic [RAW-1:0]     ram_idx;
    logic [DW-1:0]      rd_data_c;
    logic               unused_dout;

    // Only the low GW/RW bits of write data are stored.
    assign unused_dout = ^GBPORT_dout;

    // Address decode shared by the write and read paths.
    always_comb begin
        wr_en   = GBPORT_we & GBPORT_wstb;
        hit_reg = GBPORT_addr < AW'(NREG);
        hit_ram = (GBPORT_addr >= AW'(RAM_BASE)) && (GBPORT_addr <= AW'(RAM_BASE + RD - 1));
        ram_idx = GBPORT_addr[RAW-1:0];
    end

`ifdef GB_CSR_BANK_ERR_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        hit_err;
    logic        unmapped;

    // Unmapped-access counter; a write to its address clears it and beats a same-cycle increment.
    always_comb begin
        hit_err   = GBPORT_addr == AW'(NREG);
        unmapped  = (wr_en | GBPORT_rstb) & ~hit_reg & ~hit_ram & ~hit_err;
        err_cnt_d = err_cnt_q;
        if (wr_en && hit_err)
            err_cnt_d = '0;
        else if (unmapped && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end
`endif

    // Register writes and self-clear; a new write wins over the clear of the previous one.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (SC_MASK[i] && wr_pulse_q[i])
                regs_d[i*GW +: GW] = '0;
            if (wr_en && (GBPORT_addr == AW'(i))) begin
                regs_d[i*GW +: GW] = GBPORT_dout[GW-1:0];
                wr_pulse_d[i]      = 1'b1;
            end
        end
    end

    // Read mux sees pre-write state, giving read-before-write on a same-cycle collision.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (GBPORT_addr == AW'(i))
                rd_data_c[GW-1:0] = regs_q[i*GW +: GW];
        end
        if (hit_ram)
            rd_data_c[RW-1:0] = mem[ram_idx];
`ifdef GB_CSR_BANK_ERR_EN
        if (hit_err)
            rd_data_c[15:0] = err_cnt_q;
`endif
    end

    // Read pipeline: each stage loads only when a valid read passes, so the last stage holds GBPORT_din.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = GBPORT_rstb;
        if (GBPORT_rstb)
            dat_d[0] = rd_data_c;
        for (int k = 1; k < int'(RD_LAT); k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1])
                dat_d[k] = dat_q[k-1];
        end
        ram_rdata_d = mem[ram_raddr];
    end

    // Control state registers; reset flushes in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= INIT;
            wr_pulse_q  <= '0;
            ram_rdata_q <= '0;
            vld_q       <= '0;
            for (int k = 0; k < int'(RD_LAT); k++)
                dat_q[k] <= '0;
        end else begin
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            ram_rdata_q <= ram_rdata_d;
            vld_q       <= vld_d;
            dat_q       <= dat_d;
        end
    end

    // RAM storage, not reset.
    always_ff @(posedge clk) begin
        if (wr_en && hit_ram)
            mem[ram_idx] <= GBPORT_dout[RW-1:0];
    end

    assign reg_q      = regs_q;
    assign wr_pulse   = wr_pulse_q;
    assign ram_rdata  = ram_rdata_q;
    assign GBPORT_din = dat_q[RD_LAT-1];
    assign rd_valid   = vld_q[RD_LAT-1];

endmodule

// File: tb/tb_gb_csr_bank.sv
// Directed bench for gb_csr_bank: three instances share one bus and differ
// only in read latency (1, 2, 3).
module tb_gb_csr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] addr;
    logic [31:0] dout;
    logic        we, wstb, rstb;
    logic [2:0]  raddr;

    logic [31:0] din1, din2, din3;
    logic [31:0] regq1, regq2, regq3;
    logic [3:0]  wrp1, wrp2, wrp3;
    logic [3:0]  rdat1, rdat2, rdat3;
    logic        vld1, vld2, vld3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gb_csr_bank #(.NREG(4), .INIT(32'h0000A542), .SC_MASK(4'b0100), .RD_LAT(1)) d1 (
        .clk(clk), .rst(rst), .GBPORT_addr(addr), .GBPORT_dout(dout), .GBPORT_din(din1),
        .GBPORT_we(we), .GBPORT_wstb(wstb), .GBPORT_rstb(rstb), .reg_q(regq1),
        .wr_pulse(wrp1), .ram_raddr(raddr), .ram_rdata(rdat1), .rd_valid(vld1));

    gb_csr_bank #(.NREG(4), .INIT(32'h0000A542), .SC_MASK(4'b0100), .RD_LAT(2)) d2 (
        .clk(clk), .rst(rst), .GBPORT_addr(addr), .GBPORT_dout(dout), .GBPORT_din(din2),
        .GBPORT_we(we), .GBPORT_wstb(wstb), .GBPORT_rstb(rstb), .reg_q(regq2),
        .wr_pulse(wrp2), .ram_raddr(raddr), .ram_rdata(rdat2), .rd_valid(vld2));

    gb_csr_bank #(.NREG(4), .INIT(32'h0000A542), .SC_MASK(4'b0100), .RD_LAT(3)) d3 (
        .clk(clk), .rst(rst), .GBPORT_addr(addr), .GBPORT_dout(dout), .GBPORT_din(din3),
        .GBPORT_we(we), .GBPORT_wstb(wstb), .GBPORT_rstb(rstb), .reg_q(regq3),
        .wr_pulse(wrp3), .ram_raddr(raddr), .ram_rdata(rdat3), .rd_valid(vld3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic ws, input logic rs,
                       input logic [23:0] a, input logic [31:0] d);
        we = w; wstb = ws; rstb = rs; addr = a; dout = d;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if (regq1 !== 32'h0000A542) begin n_bad++; $display("FAIL rst_reg_q: got %h expected %h", regq1, 32'h0000A542); end
        n_cmp++; if (wrp1 !== 4'b0000) begin n_bad++; $display("FAIL rst_wr_pulse: got %b expected 0000", wrp1); end
        n_cmp++; if (din1 !== 32'h0) begin n_bad++; $display("FAIL rst_din: got %h expected 0", din1); end
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b expected 0", vld1); end
        n_cmp++; if (rdat1 !== 4'h0) begin n_bad++; $display("FAIL rst_ram_rdata: got %h expected 0", rdat1); end
        rst = 1'b0;
        tick();
        n_cmp++; if (regq3 !== 32'h0000A542) begin n_bad++; $display("FAIL rst_reg_q_after: got %h expected %h", regq3, 32'h0000A542); end
    endtask

    task automatic test_read_lat1();
        bus(1'b0, 1'b0, 1'b1, 24'h0, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h42) begin n_bad++; $display("FAIL rd0_din: got %h expected %h", din1, 32'h42); end
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL rd0_valid: got %b expected 1", vld1); end
        tick();
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL rd0_valid_drop: got %b expected 0", vld1); end
        n_cmp++; if (din1 !== 32'h42) begin n_bad++; $display("FAIL rd0_din_hold: got %h expected %h", din1, 32'h42); end
    endtask

    task automatic test_write();
        bus(1'b1, 1'b1, 1'b0, 24'h2, 32'hFFFF_FF3C);
        tick();
        idle();
        n_cmp++; if (regq1 !== 32'h003CA542) begin n_bad++; $display("FAIL wr2_reg_q: got %h expected %h", regq1, 32'h003CA542); end
        n_cmp++; if (wrp1 !== 4'b0100) begin n_bad++; $display("FAIL wr2_pulse: got %b expected 0100", wrp1); end
        tick();
        n_cmp++; if (regq1 !== 32'h0000A542) begin n_bad++; $display("FAIL wr2_selfclear: got %h expected %h", regq1, 32'h0000A542); end
        n_cmp++; if (wrp1 !== 4'b0000) begin n_bad++; $display("FAIL wr2_pulse_end: got %b expected 0000", wrp1); end
        bus(1'b1, 1'b1, 1'b0, 24'h1, 32'h0000_0000);
        tick();
        idle();
        n_cmp++; if (wrp1 !== 4'b0010) begin n_bad++; $display("FAIL wr1_pulse: got %b expected 0010", wrp1); end
        tick();
        n_cmp++; if (regq1 !== 32'h00000042) begin n_bad++; $display("FAIL wr1_hold: got %h expected %h", regq1, 32'h00000042); end
        bus(1'b0, 1'b1, 1'b0, 24'h0, 32'h0000_00FF);
        tick();
        idle();
        n_cmp++; if (regq1 !== 32'h00000042) begin n_bad++; $display("FAIL wstb_no_we_reg: got %h expected %h", regq1, 32'h00000042); end
        n_cmp++; if (wrp1 !== 4'b0000) begin n_bad++; $display("FAIL wstb_no_we_pulse: got %b expected 0000", wrp1); end
    endtask

    task automatic test_ram();
        bus(1'b1, 1'b1, 1'b0, 24'h45, 32'hFFFF_FFFB);
        tick();
        idle();
        raddr = 3'd5;
        tick();
        n_cmp++; if (rdat1 !== 4'hB) begin n_bad++; $display("FAIL fabric_rd: got %h expected b", rdat1); end
        n_cmp++; if (regq1 !== 32'h00000042) begin n_bad++; $display("FAIL ram_wr_no_reg: got %h expected %h", regq1, 32'h00000042); end
        bus(1'b0, 1'b0, 1'b1, 24'h45, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h0000000B) begin n_bad++; $display("FAIL host_ram_rd: got %h expected %h", din1, 32'hB); end
        bus(1'b1, 1'b1, 1'b0, 24'h45, 32'h0000_0007);
        tick();
        idle();
        n_cmp++; if (rdat1 !== 4'hB) begin n_bad++; $display("FAIL fabric_old_data: got %h expected b", rdat1); end
        tick();
        n_cmp++; if (rdat1 !== 4'h7) begin n_bad++; $display("FAIL fabric_new_data: got %h expected 7", rdat1); end
    endtask

    task automatic test_rbw();
        bus(1'b1, 1'b1, 1'b1, 24'h1, 32'h0000_0011);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h0) begin n_bad++; $display("FAIL rbw_old: got %h expected 0", din1); end
        n_cmp++; if (vld1 !== 1'b1) begin n_bad++; $display("FAIL rbw_valid: got %b expected 1", vld1); end
        n_cmp++; if (regq1 !== 32'h00001142) begin n_bad++; $display("FAIL rbw_reg_q: got %h expected %h", regq1, 32'h00001142); end
        bus(1'b0, 1'b0, 1'b1, 24'h1, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h11) begin n_bad++; $display("FAIL rbw_new: got %h expected %h", din1, 32'h11); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] pa [4];
        logic [31:0] pe [4];
        pa[0] = 24'h0;  pe[0] = 32'h42;
        pa[1] = 24'h20; pe[1] = 32'h0;
        pa[2] = 24'h1;  pe[2] = 32'h11;
        pa[3] = 24'h3;  pe[3] = 32'hC3;
        bus(1'b1, 1'b1, 1'b0, 24'h3, 32'h0000_00C3);
        tick();
        idle();
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) bus(1'b0, 1'b0, 1'b1, pa[k], 32'h0);
            else       idle();
            tick();
            if (k >= 2 && k <= 5) begin
                n_cmp++; if (vld3 !== 1'b1 || din3 !== pe[k-2]) begin n_bad++; $display("FAIL b2b_rd%0d: got valid=%b din=%h expected valid=1 din=%h", k-2, vld3, din3, pe[k-2]); end
            end else begin
                n_cmp++; if (vld3 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle%0d: got valid=%b expected 0", k, vld3); end
            end
        end
        n_cmp++; if (din3 !== 32'hC3) begin n_bad++; $display("FAIL b2b_hold: got %h expected %h", din3, 32'hC3); end
    endtask

    task automatic test_reset_inflight();
        bus(1'b0, 1'b0, 1'b1, 24'h0, 32'h0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        n_cmp++; if (vld2 !== 1'b0 || din2 !== 32'h0) begin n_bad++; $display("FAIL rst_flight_during: got valid=%b din=%h expected valid=0 din=0", vld2, din2); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (vld2 !== 1'b0 || din2 !== 32'h0) begin n_bad++; $display("FAIL rst_flight_after%0d: got valid=%b din=%h expected valid=0 din=0", k, vld2, din2); end
        end
        n_cmp++; if (regq2 !== 32'h0000A542) begin n_bad++; $display("FAIL rst_flight_reg_q: got %h expected %h", regq2, 32'h0000A542); end
    endtask

    task automatic test_err_addr();
        bus(1'b0, 1'b0, 1'b1, 24'h0, 32'h0);
        tick();
        idle();
`ifdef GB_CSR_BANK_ERR_EN
        bus(1'b0, 1'b0, 1'b1, 24'h20, 32'h0);
        tick();
        bus(1'b1, 1'b1, 1'b0, 24'h30, 32'h5);
        tick();
        bus(1'b0, 1'b0, 1'b1, 24'h60, 32'h0);
        tick();
        bus(1'b0, 1'b0, 1'b1, 24'h4, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h3) begin n_bad++; $display("FAIL err_count: got %h expected 3", din1); end
        bus(1'b1, 1'b1, 1'b0, 24'h4, 32'h0);
        tick();
        bus(1'b0, 1'b0, 1'b1, 24'h4, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h0) begin n_bad++; $display("FAIL err_clear: got %h expected 0", din1); end
`else
        bus(1'b0, 1'b0, 1'b1, 24'h4, 32'h0);
        tick();
        idle();
        n_cmp++; if (din1 !== 32'h0) begin n_bad++; $display("FAIL addr_nreg_unmapped: got %h expected 0", din1); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        raddr = 3'd0;
        idle();
        test_reset();
        test_read_lat1();
        test_write();
        test_ram();
        test_rbw();
        test_back_to_back();
        test_reset_inflight();
        test_err_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
